spm_wb_slave: RTL and testbench
===============================

# spm_wb_slave

Parametrised Wishbone scratchpad-memory slave. It is the next generation of the fixed single-byte test SPM that sits on the CPU_LS1u shrunk bus in simulation and FPGA bring-up. It adds configurable data width, depth, base address, byte-lane writes, programmable wait states, transfer abort and an optional range-error response. It is a single-port synchronous RAM behind a small request/acknowledge FSM.

## Interface
- ADDR_W, 24, byte-address width of WB_ADRi
- DATA_W, 8, data width; must be a multiple of 8 (8, 16, 32)
- DEPTH, 4096, number of DATA_W words; power of two
- BASE_ADDR, 24'h000000, byte address of word 0; aligned to DATA_W/8
- WAIT_STATES, 0, extra cycles inserted before ACK/ERR (0..15)
- clk  input  1  system clock, all logic on rising edge
- rst_n  input  1  asynchronous active-low reset
- WB_ADRi  input  ADDR_W  byte address
- WB_DATi  input  DATA_W  write data
- WB_DATo  output  DATA_W  read data, valid only while WB_ACKo=1
- WB_SELi  input  DATA_W/8  byte-lane enables for writes; ignored on reads
- WB_WEi  input  1  1 = write, 0 = read
- WB_CYCi  input  1  bus cycle active
- WB_STBi  input  1  strobe; request = WB_CYCi & WB_STBi
- WB_ACKo  output  1  single-cycle transfer acknowledge
- WB_ERRo  output  1  single-cycle error acknowledge (only with SPM_ERR_EN)

## Operation
- Reset values: WB_ACKo=0, WB_ERRo=0, WB_DATo=0, FSM=IDLE, wait counter=0. RAM contents are not reset.
- Offset = WB_ADRi − BASE_ADDR, in ADDR_W bits with wrap. Word index = offset >> log2(DATA_W/8). In range when offset < DEPTH*DATA_W/8.
- FSM states and transitions:
  - IDLE: on a request, latch address, data, sel and we. Go to WAIT with counter=WAIT_STATES−1 if WAIT_STATES>0, else go to RESP.
  - WAIT: decrement the counter each cycle. Go to RESP when the counter is 0. If WB_CYCi=0 in any WAIT cycle, abort to IDLE with no write and no ack.
  - RESP: WB_ACKo or WB_ERRo is high for exactly this cycle. Next state is IDLE unconditionally.
- The RAM access happens on the edge entering RESP.
  - Write: only lanes with WB_SELi[i]=1 are updated. A write with SEL=0 still ACKs.
  - Read: WB_DATo is loaded with the word. WB_DATo returns to 0 in the cycle after RESP.
- Latched request fields are used, so master changes to ADR/DAT after sampling are ignored.
- WB_CYCi dropping during RESP has no effect; the access has already completed.
- Reset asserted mid-transfer returns to IDLE immediately. ACK/ERR drop asynchronously, and no write occurs unless the entering-RESP edge already happened.

## Timing
- Request sampled at edge k. ACK/ERR is high in the cycle after edge k+WAIT_STATES, so latency is WAIT_STATES+1 cycles.
- Minimum request spacing is WAIT_STATES+2 cycles. A strobe still held in the cycle after ACK is treated as a new request.
- ACK and ERR are never high together and are never high for two consecutive cycles.

## Configuration
- SPM_ERR_EN defined: an out-of-range request completes with WB_ERRo instead of WB_ACKo after the same latency. There is no RAM write, and WB_DATo=0.
- SPM_ERR_EN undefined: the WB_ERRo port is tied to 0. Out-of-range requests alias to word index mod DEPTH and ACK normally.

## Test plan
- DATA_W=8, WAIT_STATES=0: write 8'hA5 to 24'h000010, then read 24'h000010 -> ACK one cycle after each request, read data 8'hA5.
- DATA_W=32: write 32'h11223344 SEL=4'hF, then write 32'hAABBCCDD SEL=4'b0101, then read -> 32'h11BB33DD.
- WAIT_STATES=3: read request at cycle 0 -> ACK exactly in cycle 4. Drop CYC at cycle 2 of a write -> no ACK, and a later read returns the old value.
- Back-to-back: hold STB for 4 cycles with WAIT_STATES=0 -> ACKs in cycles 1 and 3 (two transfers).
- Range, DEPTH=256, BASE_ADDR=24'h001000, DATA_W=8, access at 24'h001100:
  - With SPM_ERR_EN: ERR=1, ACK=0, and 24'h001000 is unchanged.
  - Without SPM_ERR_EN: ACK=1, and the write lands at word 0.
- Pull rst_n low during WAIT -> ACK/ERR/DATo=0 immediately, FSM back in IDLE, and the next request is served normally.

Source files
------------

// File: rtl/spm_wb_slave.sv
// Wishbone scratchpad-memory slave: a single-port synchronous RAM behind a small
// request/acknowledge FSM with programmable wait states, byte-lane writes and
// transfer abort on CYC drop.
// Optional feature macro SPM_ERR_EN: out-of-range requests complete with WB_ERRo and
// have no effect on the RAM. When undefined, WB_ERRo is tied low and out-of-range
// accesses alias to word index mod DEPTH.
module spm_wb_slave #(
  parameter int unsigned        ADDR_W      = 24,
  parameter int unsigned        DATA_W      = 8,
  parameter int unsigned        DEPTH       = 4096,
  parameter logic [ADDR_W-1:0]  BASE_ADDR   = '0,
  parameter int unsigned        WAIT_STATES = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_W-1:0]     WB_ADRi,
  input  logic [DATA_W-1:0]     WB_DATi,
  output logic [DATA_W-1:0]     WB_DATo,
  input  logic [DATA_W/8-1:0]   WB_SELi,
  input  logic                  WB_WEi,
  input  logic                  WB_CYCi,
  input  logic                  WB_STBi,
  output logic                  WB_ACKo,
  output logic                  WB_ERRo
);

  localparam int unsigned NB    = DATA_W / 8;
  localparam int unsigned LSB   = $clog2(NB);
  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam logic [3:0]  WaitInit = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q;
  logic [DATA_W-1:0] dat_q;
  logic [NB-1:0]     sel_q;
  logic              we_q;
  logic [DATA_W-1:0] rdata_q;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              req;
  logic              access;
  logic              use_in;
  logic [ADDR_W-1:0] offset;
  logic [IDX_W-1:0]  idx_in;
  logic [IDX_W-1:0]  acc_idx;
  logic [DATA_W-1:0] acc_dat;
  logic [NB-1:0]     acc_sel;
  logic              acc_we;
  logic              acc_ok;
  logic              unused_offset;

  assign req    = WB_CYCi & WB_STBi;
  assign offset = WB_ADRi - BASE_ADDR;
  // Index bits above IDX_W are dropped, so out-of-range addresses alias mod DEPTH.
  assign idx_in = offset[LSB +: IDX_W];
  assign unused_offset = ^offset;

  // With zero wait states the access edge is the sampling edge, so the live bus
  // fields are used; otherwise the fields latched in IDLE are used.
  assign use_in  = (state_q == StIdle);
  assign acc_idx = use_in ? idx_in  : idx_q;
  assign acc_dat = use_in ? WB_DATi : dat_q;
  assign acc_sel = use_in ? WB_SELi : sel_q;
  assign acc_we  = use_in ? WB_WEi  : we_q;

`ifdef SPM_ERR_EN
  localparam longint unsigned Span = longint'(DEPTH) * longint'(NB);

  logic in_range;
  logic oor_q;
  logic resp_err_q;

  assign in_range = (64'(offset) < Span);
  assign acc_ok   = use_in ? in_range : ~oor_q;

  // Remember range status of the request and the response type of the access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      oor_q      <= 1'b0;
      resp_err_q <= 1'b0;
    end else begin
      if (state_q == StIdle && req) oor_q <= ~in_range;
      if (access) resp_err_q <= ~acc_ok;
    end
  end

  assign WB_ACKo = (state_q == StResp) & ~resp_err_q;
  assign WB_ERRo = (state_q == StResp) &  resp_err_q;
`else
  assign acc_ok  = 1'b1;
  assign WB_ACKo = (state_q == StResp);
  assign WB_ERRo = 1'b0;
`endif

  // Next-state logic; access marks the edge entering RESP.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    access  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req) begin
          if (WAIT_STATES > 0) begin
            state_d = StWait;
            cnt_d   = WaitInit;
          end else begin
            state_d = StResp;
            access  = 1'b1;
          end
        end
      end
      StWait: begin
        if (!WB_CYCi) begin
          state_d = StIdle;
          cnt_d   = 4'd0;
        end else if (cnt_q == 4'd0) begin
          state_d = StResp;
          access  = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM state and wait counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Capture the request fields so later master changes are ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q <= '0;
      dat_q <= '0;
      sel_q <= '0;
      we_q  <= 1'b0;
    end else if (state_q == StIdle && req) begin
      idx_q <= idx_in;
      dat_q <= WB_DATi;
      sel_q <= WB_SELi;
      we_q  <= WB_WEi;
    end
  end

  // RAM write, byte-lane masked; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (access && acc_we && acc_ok) begin
      for (int unsigned i = 0; i < NB; i++) begin
        if (acc_sel[i]) mem[acc_idx][8*i +: 8] <= acc_dat[8*i +: 8];
      end
    end
  end

  // Read data is held only for the RESP cycle and is zero otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else if (access && !acc_we && acc_ok) begin
      rdata_q <= mem[acc_idx];
    end else begin
      rdata_q <= '0;
    end
  end

  assign WB_DATo = rdata_q;

endmodule

// File: tb/tb_spm_wb_slave.sv
// Directed, scoreboard-driven bench for spm_wb_slave. Three instances share one
// address/data bus with separate CYC/STB:
//   u0: 8-bit, DEPTH 4096, base 0, no wait states
//   u1: 32-bit, DEPTH 1024, base 0, 3 wait states
//   u2: 8-bit, DEPTH 256, base 24'h001000, no wait states (range behaviour)
module tb_spm_wb_slave;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [23:0] adr;
  logic [31:0] wdat;
  logic [3:0]  sel;
  logic        we;
  logic [2:0]  cyc;
  logic [2:0]  stb;
  logic        ack0, ack1, ack2, err0, err1, err2;
  logic [7:0]  dato0, dato2;
  logic [31:0] dato1;

  always #5 clk = ~clk;

  spm_wb_slave #(.ADDR_W(24), .DATA_W(8), .DEPTH(4096), .BASE_ADDR(24'h000000),
                 .WAIT_STATES(0)) u0 (
    .clk(clk), .rst_n(rst_n), .WB_ADRi(adr), .WB_DATi(wdat[7:0]), .WB_DATo(dato0),
    .WB_SELi(sel[0:0]), .WB_WEi(we), .WB_CYCi(cyc[0]), .WB_STBi(stb[0]),
    .WB_ACKo(ack0), .WB_ERRo(err0)
  );

  spm_wb_slave #(.ADDR_W(24), .DATA_W(32), .DEPTH(1024), .BASE_ADDR(24'h000000),
                 .WAIT_STATES(3)) u1 (
    .clk(clk), .rst_n(rst_n), .WB_ADRi(adr), .WB_DATi(wdat), .WB_DATo(dato1),
    .WB_SELi(sel), .WB_WEi(we), .WB_CYCi(cyc[1]), .WB_STBi(stb[1]),
    .WB_ACKo(ack1), .WB_ERRo(err1)
  );

  spm_wb_slave #(.ADDR_W(24), .DATA_W(8), .DEPTH(256), .BASE_ADDR(24'h001000),
                 .WAIT_STATES(0)) u2 (
    .clk(clk), .rst_n(rst_n), .WB_ADRi(adr), .WB_DATi(wdat[7:0]), .WB_DATo(dato2),
    .WB_SELi(sel[0:0]), .WB_WEi(we), .WB_CYCi(cyc[2]), .WB_STBi(stb[2]),
    .WB_ACKo(ack2), .WB_ERRo(err2)
  );

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic logic get_ack(input int d);
    case (d)
      0:       return ack0;
      1:       return ack1;
      default: return ack2;
    endcase
  endfunction

  function automatic logic get_err(input int d);
    case (d)
      0:       return err0;
      1:       return err1;
      default: return err2;
    endcase
  endfunction

  function automatic logic [31:0] get_dat(input int d);
    case (d)
      0:       return {24'h0, dato0};
      1:       return dato1;
      default: return {24'h0, dato2};
    endcase
  endfunction

  task automatic push(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic check(input logic [31:0] obs);
    exp_t e;
    n_cmp++;
    if (sb.size() == 0) begin
      n_bad++;
      $error("FAIL sb_empty: observed %h, nothing was expected", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val)
      else begin
        n_bad++;
        $error("FAIL %s: observed %h required %h", e.tag, obs, e.val);
      end
    end
  endtask

  // One bus transfer; lat is the number of edges from the sampling edge until
  // ACK/ERR is seen (0 = none within the budget). CYC drops after abort_at edges.
  task automatic xfer(input int d, input logic we_v, input logic [23:0] a,
                      input logic [31:0] wd, input logic [3:0] s, input int abort_at,
                      output int lat, output logic [31:0] rd, output logic ack_v,
                      output logic err_v);
    adr    = a;
    wdat   = wd;
    sel    = s;
    we     = we_v;
    cyc[d] = 1'b1;
    stb[d] = 1'b1;
    lat    = 0;
    rd     = '0;
    ack_v  = 1'b0;
    err_v  = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (abort_at == i) cyc[d] = 1'b0;
      if (get_ack(d) || get_err(d)) begin
        lat   = i;
        ack_v = get_ack(d);
        err_v = get_err(d);
        rd    = get_dat(d);
        break;
      end
    end
    cyc[d] = 1'b0;
    stb[d] = 1'b0;
  endtask

  // Transfer plus response checks, then one more cycle where ACK/ERR/DATo must be low.
  task automatic run(input string tag, input int d, input logic we_v, input logic [23:0] a,
                     input logic [31:0] wd, input logic [3:0] s, input int abort_at,
                     input int e_lat, input logic e_ack, input logic e_err,
                     input logic [31:0] e_rd);
    int          lat;
    logic [31:0] rd;
    logic        ack_v, err_v;
    push({tag, "_lat"}, 32'(e_lat));
    push({tag, "_ack"}, {31'h0, e_ack});
    push({tag, "_err"}, {31'h0, e_err});
    push({tag, "_rdata"}, e_rd);
    push({tag, "_resp_clr"}, 32'h0);
    push({tag, "_dato_clr"}, 32'h0);
    xfer(d, we_v, a, wd, s, abort_at, lat, rd, ack_v, err_v);
    check(32'(lat));
    check({31'h0, ack_v});
    check({31'h0, err_v});
    check(rd);
    @(posedge clk);
    #1;
    check({30'h0, get_ack(d), get_err(d)});
    check(get_dat(d));
  endtask

  initial begin
    int          lat;
    logic [31:0] rd;
    logic        ack_v, err_v;
    logic [3:0]  ackv;

    rst_n = 1'b0;
    adr   = '0;
    wdat  = '0;
    sel   = '0;
    we    = 1'b0;
    cyc   = '0;
    stb   = '0;

    // Reset state
    push("rst_ack_err", 32'h0);
    push("rst_dato0", 32'h0);
    push("rst_dato1", 32'h0);
    push("rst_dato2", 32'h0);
    repeat (3) @(posedge clk);
    #1;
    check({26'h0, ack0, ack1, ack2, err0, err1, err2});
    check({24'h0, dato0});
    check(dato1);
    check({24'h0, dato2});
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 8-bit, zero wait states
    run("u0_wr", 0, 1'b1, 24'h000010, 32'hA5, 4'h1, 0, 1, 1'b1, 1'b0, 32'h0);
    run("u0_rd", 0, 1'b0, 24'h000010, 32'h0, 4'h0, 0, 1, 1'b1, 1'b0, 32'hA5);

    // 32-bit lanes with three wait states
    run("u1_wr_full", 1, 1'b1, 24'h000000, 32'h11223344, 4'hF, 0, 4, 1'b1, 1'b0, 32'h0);
    run("u1_wr_lanes", 1, 1'b1, 24'h000000, 32'hAABBCCDD, 4'b0101, 0, 4, 1'b1, 1'b0, 32'h0);
    run("u1_rd_lanes", 1, 1'b0, 24'h000000, 32'h0, 4'h0, 0, 4, 1'b1, 1'b0, 32'h11BB33DD);

    // Abort: CYC dropped two cycles into the wait period
    run("u1_abort", 1, 1'b1, 24'h000000, 32'hDEADBEEF, 4'hF, 2, 0, 1'b0, 1'b0, 32'h0);
    run("u1_rd_after_abort", 1, 1'b0, 24'h000000, 32'h0, 4'h0, 0, 4, 1'b1, 1'b0,
        32'h11BB33DD);

    // Back-to-back: strobe held four cycles gives two transfers
    push("u0_b2b_ack_pattern", 32'h5);
    adr    = 24'h000010;
    we     = 1'b0;
    cyc[0] = 1'b1;
    stb[0] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      ackv[i] = ack0;
    end
    cyc[0] = 1'b0;
    stb[0] = 1'b0;
    check({28'h0, ackv});
    @(posedge clk);
    #1;

    // Range behaviour at base 24'h001000, DEPTH 256
    run("u2_wr_base", 2, 1'b1, 24'h001000, 32'h5A, 4'h1, 0, 1, 1'b1, 1'b0, 32'h0);
`ifdef SPM_ERR_EN
    run("u2_wr_oor", 2, 1'b1, 24'h001100, 32'h77, 4'h1, 0, 1, 1'b0, 1'b1, 32'h0);
    run("u2_rd_oor", 2, 1'b0, 24'h001100, 32'h0, 4'h0, 0, 1, 1'b0, 1'b1, 32'h0);
    run("u2_rd_base", 2, 1'b0, 24'h001000, 32'h0, 4'h0, 0, 1, 1'b1, 1'b0, 32'h5A);
`else
    run("u2_wr_oor", 2, 1'b1, 24'h001100, 32'h77, 4'h1, 0, 1, 1'b1, 1'b0, 32'h0);
    run("u2_rd_base", 2, 1'b0, 24'h001000, 32'h0, 4'h0, 0, 1, 1'b1, 1'b0, 32'h77);
`endif

    // Reset during RESP: ACK and DATo drop asynchronously
    run("u1_wr_w1", 1, 1'b1, 24'h000004, 32'h01020304, 4'hF, 0, 4, 1'b1, 1'b0, 32'h0);
    push("u1_resp_lat", 32'd4);
    push("u1_resp_rdata", 32'h01020304);
    push("u1_resp_rst_ack_err", 32'h0);
    push("u1_resp_rst_dato", 32'h0);
    xfer(1, 1'b0, 24'h000004, 32'h0, 4'h0, 0, lat, rd, ack_v, err_v);
    check(32'(lat));
    check(rd);
    rst_n = 1'b0;
    #1;
    check({30'h0, ack1, err1});
    check(dato1);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Reset during WAIT: write discarded, FSM idle, next request served normally
    push("u1_wait_rst_outs", 32'h0);
    adr    = 24'h000004;
    wdat   = 32'hCAFEF00D;
    sel    = 4'hF;
    we     = 1'b1;
    cyc[1] = 1'b1;
    stb[1] = 1'b1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    cyc[1] = 1'b0;
    stb[1] = 1'b0;
    rst_n  = 1'b0;
    #1;
    check({ack1, err1, dato1[29:0]});
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    run("u1_rd_after_rst", 1, 1'b0, 24'h000004, 32'h0, 4'h0, 0, 4, 1'b1, 1'b0, 32'h01020304);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
